// File: rtl/output_port_arbiter.sv
// Per-output-port switch stage: round-robin pick of one FIFO head bound for this
// port, zero-latency pop, one-deep output register with valid/enable handshake.
module output_port_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned CNT_W = 16,
  parameter type         packet_t = logic [31:0]
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  packet_t [N-1:0]      i_data,
  input  logic    [N-1:0]      i_data_val,
  input  logic    [N-1:0]      i_req,
  output logic    [N-1:0]      o_en,
  output packet_t              o_data,
  output logic                 o_data_val,
  input  logic                 i_en,
  output logic    [CNT_W-1:0]  o_pkt_cnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  packet_t          data_q, data_d;
  logic             val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     eligible;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  int unsigned      scan_idx;
  logic             can_load;
  logic             xfer;
  logic             grant;

  assign eligible = i_req & i_data_val;
  assign can_load = ce & (~val_q | i_en);
  assign xfer     = ce & val_q & i_en;
  assign grant    = reset_n & can_load & grant_found;

  // Round-robin scan starting at the priority pointer, wrapping modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (!grant_found && eligible[PTR_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // Pop strobe shares the edge on which the packet is captured.
  always_comb begin
    o_en = '0;
    if (grant) begin
      o_en = N'(1) << grant_idx;
    end
  end

  always_comb begin
    data_d = data_q;
    val_d  = val_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (grant) begin
      data_d = i_data[grant_idx];
      val_d  = 1'b1;
      ptr_d  = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
    end else if (xfer) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      val_q  <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      val_q  <= val_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data     = data_q;
  assign o_data_val = val_q;
  assign o_pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed vector table, counter wrap, mid-run
// reset, then random traffic against a distance-based round-robin model.
module tb_output_port_arbiter;

  localparam int unsigned N     = 5;
  localparam int unsigned CNT_W = 16;
  typedef logic [31:0] pkt_t;

  logic              clk = 1'b0;
  logic              reset_n, ce, i_en;
  pkt_t [N-1:0]      i_data;
  logic [N-1:0]      i_data_val, i_req, o_en;
  pkt_t              o_data;
  logic              o_data_val;
  logic [CNT_W-1:0]  o_pkt_cnt;

  always #5 clk = ~clk;

  output_port_arbiter #(.N(N), .CNT_W(CNT_W), .packet_t(pkt_t)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_data(i_data),
    .i_data_val(i_data_val), .i_req(i_req), .o_en(o_en), .o_data(o_data),
    .o_data_val(o_data_val), .i_en(i_en), .o_pkt_cnt(o_pkt_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_p   = 0;
  bit          m_val = 1'b0;
  pkt_t        m_data = '0;
  int unsigned m_cnt = 0;

  typedef struct {
    bit          rst_n;
    bit          ce;
    bit          ien;
    logic [4:0]  req;
    logic [4:0]  val;
    logic [4:0]  en;
    bit          dv;
    logic [31:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pkt_t pk(input int k);
    return pkt_t'(32'hD0 + k);
  endfunction

  // Closest eligible input at or after the pointer, measured as rotational distance.
  function automatic int pick(input logic [N-1:0] elig, input int p);
    int best = -1;
    int bd = N;
    for (int k = 0; k < N; k++) begin
      if (elig[k]) begin
        int d = (k - p + N) % N;
        if (d < bd) begin
          bd = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  // One clock: check o_en before the edge, advance the model, check registers after.
  task automatic step(input bit chk, output logic [N-1:0] en_seen);
    logic [N-1:0] elig, exp_en;
    int g;
    bit can_load, xfer;
    elig     = i_req & i_data_val;
    g        = pick(elig, m_p);
    can_load = ce && (!m_val || i_en);
    xfer     = ce && m_val && i_en;
    exp_en   = (reset_n && can_load && g >= 0) ? (N'(1) << g) : '0;
    #1;
    en_seen = o_en;
    if (chk) check("o_en", 32'(o_en), 32'(exp_en));
    @(posedge clk);
    if (!reset_n) begin
      m_val = 1'b0; m_data = '0; m_cnt = 0; m_p = 0;
    end else if (ce) begin
      if (xfer) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (can_load && g >= 0) begin
        m_data = i_data[3'(g)];
        m_val  = 1'b1;
        m_p    = (g + 1) % N;
      end else if (xfer) begin
        m_val = 1'b0;
      end
    end
    #1;
    if (chk) begin
      check("o_data_val", 32'(o_data_val), 32'(m_val));
      check("o_data", o_data, m_data);
      check("o_pkt_cnt", 32'(o_pkt_cnt), m_cnt);
    end
  endtask

  task automatic add(input bit r, input bit c, input bit ie, input logic [4:0] rq,
                     input logic [4:0] v, input logic [4:0] en, input bit dv,
                     input logic [31:0] d, input logic [15:0] cn);
    vec_t x;
    x.rst_n = r; x.ce = c; x.ien = ie; x.req = rq; x.val = v;
    x.en = en; x.dv = dv; x.data = d; x.cnt = cn;
    tbl.push_back(x);
  endtask

  initial begin
    logic [N-1:0] en_seen;
    reset_n = 1'b0; ce = 1'b1; i_en = 1'b1;
    i_req = '0; i_data_val = '0;
    for (int k = 0; k < N; k++) i_data[k] = pk(k);

    // Directed table: rst_n ce ien req val | en dv data cnt
    add(0,1,1,5'h1F,5'h1F, 5'h00,0,32'h0,   16'd0);  // reset, all eligible
    add(0,1,1,5'h1F,5'h1F, 5'h00,0,32'h0,   16'd0);
    add(1,1,1,5'h1F,5'h1F, 5'h01,1,pk(0),   16'd0);  // first grant, ptr->1
    add(1,1,1,5'h15,5'h15, 5'h04,1,pk(2),   16'd1);  // 0,2,4 rotate
    add(1,1,1,5'h15,5'h15, 5'h10,1,pk(4),   16'd2);
    add(1,1,1,5'h15,5'h15, 5'h01,1,pk(0),   16'd3);  // ptr->1
    for (int i = 0; i < 4; i++)
      add(1,1,0,5'h0A,5'h0A, 5'h00,1,pk(0), 16'd3);  // stalled output
    add(1,1,1,5'h0A,5'h0A, 5'h02,1,pk(1),   16'd4);  // release: input 1
    add(1,1,1,5'h08,5'h08, 5'h08,1,pk(3),   16'd5);  // only input 3
    add(1,1,1,5'h08,5'h00, 5'h00,0,pk(3),   16'd6);  // req without val ignored
    add(1,1,1,5'h08,5'h08, 5'h08,1,pk(3),   16'd6);
    for (int i = 0; i < 3; i++)
      add(1,0,1,5'h1F,5'h1F, 5'h00,1,pk(3), 16'd6);  // ce low freezes all
    add(1,1,1,5'h1F,5'h1F, 5'h10,1,pk(4),   16'd7);  // ptr was 4
    add(1,1,1,5'h1F,5'h1F, 5'h01,1,pk(0),   16'd8);
    add(0,1,1,5'h1F,5'h1F, 5'h00,0,32'h0,   16'd0);  // reset mid-run
    add(1,1,1,5'h1F,5'h1F, 5'h01,1,pk(0),   16'd0);
    add(1,1,1,5'h00,5'h00, 5'h00,0,pk(0),   16'd1);  // drain, no new load

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n; ce = tbl[i].ce; i_en = tbl[i].ien;
      i_req = tbl[i].req; i_data_val = tbl[i].val;
      step(1'b1, en_seen);
      check($sformatf("tbl%0d_en", i),   32'(en_seen),    32'(tbl[i].en));
      check($sformatf("tbl%0d_dv", i),   32'(o_data_val), 32'(tbl[i].dv));
      check($sformatf("tbl%0d_data", i), o_data,          tbl[i].data);
      check($sformatf("tbl%0d_cnt", i),  32'(o_pkt_cnt),  32'(tbl[i].cnt));
    end

    // Counter wrap: one load then 65535 back-to-back transfers reach FFFF.
    reset_n = 1'b0; step(1'b0, en_seen);
    reset_n = 1'b1; ce = 1'b1; i_en = 1'b1; i_req = '1; i_data_val = '1;
    for (int i = 0; i < 65536; i++) step(1'b0, en_seen);
    check("cnt_ffff", 32'(o_pkt_cnt), 32'h0000_FFFF);
    check("cnt_model", 32'(o_pkt_cnt), m_cnt);
    step(1'b1, en_seen);
    check("cnt_wrap", 32'(o_pkt_cnt), 32'h0);

    // Reset while a packet is buffered.
    check("dv_before_rst", 32'(o_data_val), 32'h1);
    reset_n = 1'b0;
    step(1'b1, en_seen);
    check("rst_no_pop", 32'(en_seen), 32'h0);
    check("rst_dv", 32'(o_data_val), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(99) >= 2);
      ce         = ($urandom_range(9) != 0);
      i_en       = ($urandom_range(9) < 7);
      i_req      = N'($urandom);
      i_data_val = N'($urandom);
      for (int k = 0; k < N; k++) i_data[k] = $urandom;
      step(1'b1, en_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
